data_mem_unit: RTL and testbench

- Unified data/instruction memory port for the 5-stage pipeline, addressed from the MEM stage or from the I-cache refill path.
- Contains a 64-bit-wide synthesizable RAM with byte-lane writes and combinational sized reads with sign or zero extension.
- Also decodes a CLINT mtimecmp MMIO register, redirecting those accesses to the CSR block.

---
 rtl/data_mem_unit.sv | 140 ++++++++++++++
 tb/tb_data_mem_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/data_mem_unit.sv
// Unified data/instruction memory port: 64-bit byte-lane RAM with sized, extended reads,
// plus a CLINT mtimecmp MMIO redirect.
module data_mem_unit #(
    parameter logic [63:0] BASE_ADDR  = 64'h8000_0000,
    parameter int          DEPTH      = 4096,
    parameter logic [63:0] MTCMP_ADDR = 64'h0200_4000,
    parameter string       INIT_FILE  = "mem.hex"
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        ena_i,
    input  logic        wen_i,
    input  logic [3:0]  mem_mask_i,
    input  logic [63:0] addr_i,
    input  logic [63:0] wdata_i,
    input  logic [1:0]  sel_memdata_i,
    input  logic [63:0] mtcmp_rdata_i,
    output logic [63:0] rdata_o,
    output logic        mtcmp_we_o,
    output logic        mtcmp_re_o,
    output logic [63:0] mtcmp_wdata_o,
    output logic        addr_err_o
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [63:0] RAM_BYTES = 64'(DEPTH) << 3;

    logic [63:0] ram_q [DEPTH];

    localparam string unused_init_file = INIT_FILE;

    logic [63:0]   offset;
    logic [AW-1:0] word_idx;
    logic [2:0]    lane;
    logic          in_range;
    logic          mmio_hit;
    logic          unused_offset_bits;

    assign offset             = addr_i - BASE_ADDR;
    assign word_idx           = offset[AW+2:3];
    assign lane               = addr_i[2:0];
    assign in_range           = (addr_i >= BASE_ADDR) && (offset < RAM_BYTES);
    assign mmio_hit           = (addr_i[63:3] == MTCMP_ADDR[63:3]);
    assign unused_offset_bits = ^{offset[63:AW+3], offset[2:0]};

    logic       mask_valid;
    logic       misaligned;
    logic [3:0] size_bytes;

    always_comb begin
        mask_valid = 1'b1;
        misaligned = 1'b0;
        size_bytes = 4'd0;
        unique case (mem_mask_i)
            4'b0001: size_bytes = 4'd1;
            4'b0010: begin size_bytes = 4'd2; misaligned = lane[0];      end
            4'b0100: begin size_bytes = 4'd4; misaligned = |lane[1:0];   end
            4'b1000: begin size_bytes = 4'd8; misaligned = |lane;        end
            default: mask_valid = 1'b0;
        endcase
    end

    logic access_err;
    logic ram_hit;
    logic mmio_ok;

    assign access_err = ena_i && ((!in_range && !mmio_hit) || misaligned || !mask_valid);
    assign ram_hit    = rst_ni && ena_i && in_range && !access_err;
    assign mmio_ok    = rst_ni && ena_i && mmio_hit && !access_err;

    // Read path: pre-write contents, field shifted down from its lane then extended.
    logic [63:0] ram_word;
    logic [63:0] shifted;
    logic        sign_ext;
    logic [63:0] load_ext;

    assign ram_word = ram_q[word_idx];
    assign shifted  = ram_word >> {lane, 3'b000};
    assign sign_ext = (sel_memdata_i == 2'b00);

    always_comb begin
        load_ext = 64'd0;
        unique case (mem_mask_i)
            4'b0001: load_ext = {{56{sign_ext & shifted[7]}},  shifted[7:0]};
            4'b0010: load_ext = {{48{sign_ext & shifted[15]}}, shifted[15:0]};
            4'b0100: load_ext = {{32{sign_ext & shifted[31]}}, shifted[31:0]};
            4'b1000: load_ext = shifted;
            default: load_ext = 64'd0;
        endcase
    end

    always_comb begin
        rdata_o = 64'd0;
        if (!wen_i) begin
            if (ram_hit)
                rdata_o = load_ext;
            else if (mmio_ok)
                rdata_o = mtcmp_rdata_i;
        end
    end

    assign mtcmp_re_o    = mmio_ok && !wen_i;
    assign mtcmp_we_o    = mmio_ok && wen_i;
    assign mtcmp_wdata_o = mtcmp_we_o ? wdata_i : 64'd0;

    // Write path: store data moved up to its lane, then per-byte enables over lane..lane+size-1.
    logic [63:0] wdata_lane;
    logic [3:0]  lane_end;
    logic [7:0]  byte_en;

    assign wdata_lane = wdata_i << {lane, 3'b000};
    assign lane_end   = {1'b0, lane} + size_bytes;

    for (genvar gi = 0; gi < 8; gi++) begin : g_byte_en
        assign byte_en[gi] = ram_hit && wen_i
                             && (4'(gi) >= {1'b0, lane}) && (4'(gi) < lane_end);
    end

    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 8; b++) begin
            if (byte_en[b])
                ram_q[word_idx][b*8 +: 8] <= wdata_lane[b*8 +: 8];
        end
    end

    logic addr_err_q;
    logic addr_err_d;

    assign addr_err_d = addr_err_q | access_err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            addr_err_q <= 1'b0;
        else
            addr_err_q <= addr_err_d;
    end

    assign addr_err_o = addr_err_q;

endmodule

// File: tb/tb_data_mem_unit.sv
// Scoreboard bench for data_mem_unit: directed transactions push expected results,
// a negedge monitor pops and compares whenever an access is presented.
module tb_data_mem_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic        wen;
    logic [3:0]  mask;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [1:0]  sel;
    logic [63:0] mt_rdata;
    logic [63:0] rdata;
    logic        mt_we;
    logic        mt_re;
    logic [63:0] mt_wdata;
    logic        addr_err;

    always #5 clk = ~clk;

    data_mem_unit dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .ena_i         (ena),
        .wen_i         (wen),
        .mem_mask_i    (mask),
        .addr_i        (addr),
        .wdata_i       (wdata),
        .sel_memdata_i (sel),
        .mtcmp_rdata_i (mt_rdata),
        .rdata_o       (rdata),
        .mtcmp_we_o    (mt_we),
        .mtcmp_re_o    (mt_re),
        .mtcmp_wdata_o (mt_wdata),
        .addr_err_o    (addr_err)
    );

    typedef struct {
        string       name;
        logic [63:0] rdata;
        logic        we;
        logic        re;
        logic [63:0] wd;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    localparam logic [3:0] MB = 4'b0001;
    localparam logic [3:0] MH = 4'b0010;
    localparam logic [3:0] MW = 4'b0100;
    localparam logic [3:0] MD = 4'b1000;

    task automatic issue(input string nm, input logic rst_v, input logic wen_v,
                         input logic [3:0] mask_v, input logic [63:0] addr_v,
                         input logic [63:0] wd_v, input logic [1:0] sel_v,
                         input logic [63:0] mtr_v, input logic [63:0] e_rdata,
                         input logic e_we, input logic e_re, input logic [63:0] e_wd,
                         input logic e_err);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n    = rst_v;
        ena      = 1'b1;
        wen      = wen_v;
        mask     = mask_v;
        addr     = addr_v;
        wdata    = wd_v;
        sel      = sel_v;
        mt_rdata = mtr_v;
        e.name  = nm;
        e.rdata = e_rdata;
        e.we    = e_we;
        e.re    = e_re;
        e.wd    = e_wd;
        e.err   = e_err;
        sb.push_back(e);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        ena = 1'b0;
        wen = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (ena) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_access: rdata=%h with no expected entry", rdata);
                end else begin
                    e = sb.pop_front();
                    if (rdata !== e.rdata || mt_we !== e.we || mt_re !== e.re ||
                        mt_wdata !== e.wd || addr_err !== e.err) begin
                        n_bad++;
                        $display("FAIL %s: got rdata=%h we=%b re=%b wdata=%h err=%b, want rdata=%h we=%b re=%b wdata=%h err=%b",
                                 e.name, rdata, mt_we, mt_re, mt_wdata, addr_err,
                                 e.rdata, e.we, e.re, e.wd, e.err);
                    end else begin
                        $display("ok   %s: rdata=%h we=%b re=%b wdata=%h err=%b",
                                 e.name, rdata, mt_we, mt_re, mt_wdata, addr_err);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        int waited;
        rst_n = 1'b0; ena = 1'b0; wen = 1'b0; mask = 4'd0; addr = 64'd0;
        wdata = 64'd0; sel = 2'd0; mt_rdata = 64'd0;

        issue("reset_read",   1'b0, 1'b0, MD, 64'h8000_0000, 64'd0, 2'b00, 64'd0, 64'd0, 0, 0, 64'd0, 0);
        issue("st_d_0",       1'b1, 1'b1, MD, 64'h8000_0000, 64'hCAFE_BABE_1234_5678, 2'b00, 64'd0, 64'd0, 0, 0, 64'd0, 0);
        issue("st_d_8",       1'b1, 1'b1, MD, 64'h8000_0008, 64'h1122_3344_5566_7788, 2'b00, 64'd0, 64'd0, 0, 0, 64'd0, 0);
        issue("ld_d_8",       1'b1, 1'b0, MD, 64'h8000_0008, 64'd0, 2'b00, 64'd0, 64'h1122_3344_5566_7788, 0, 0, 64'd0, 0);
        issue("st_d_10",      1'b1, 1'b1, MD, 64'h8000_0010, 64'h0102_0304_0506_0708, 2'b00, 64'd0, 64'd0, 0, 0, 64'd0, 0);
        issue("st_b_13",      1'b1, 1'b1, MB, 64'h8000_0013, 64'hAAAA_AAAA_AAAA_AAF0, 2'b00, 64'd0, 64'd0, 0, 0, 64'd0, 0);
        issue("ld_b_13_sext", 1'b1, 1'b0, MB, 64'h8000_0013, 64'd0, 2'b00, 64'd0, 64'hFFFF_FFFF_FFFF_FFF0, 0, 0, 64'd0, 0);
        issue("ld_b_13_zext", 1'b1, 1'b0, MB, 64'h8000_0013, 64'd0, 2'b01, 64'd0, 64'h0000_0000_0000_00F0, 0, 0, 64'd0, 0);
        issue("ld_w_10_zext", 1'b1, 1'b0, MW, 64'h8000_0010, 64'd0, 2'b01, 64'd0, 64'h0000_0000_F006_0708, 0, 0, 64'd0, 0);
        issue("ld_d_10",      1'b1, 1'b0, MD, 64'h8000_0010, 64'd0, 2'b00, 64'd0, 64'h0102_0304_F006_0708, 0, 0, 64'd0, 0);
        issue("st_w_4",       1'b1, 1'b1, MW, 64'h8000_0004, 64'hDEAD_BEEF_8765_4321, 2'b00, 64'd0, 64'd0, 0, 0, 64'd0, 0);
        issue("ld_h_6_sext",  1'b1, 1'b0, MH, 64'h8000_0006, 64'd0, 2'b00, 64'd0, 64'hFFFF_FFFF_FFFF_8765, 0, 0, 64'd0, 0);
        issue("ld_w_4_zext",  1'b1, 1'b0, MW, 64'h8000_0004, 64'd0, 2'b01, 64'd0, 64'h0000_0000_8765_4321, 0, 0, 64'd0, 0);
        issue("ld_h_0_sel10", 1'b1, 1'b0, MH, 64'h8000_0000, 64'd0, 2'b10, 64'd0, 64'h0000_0000_0000_5678, 0, 0, 64'd0, 0);
        issue("ld_d_0",       1'b1, 1'b0, MD, 64'h8000_0000, 64'd0, 2'b00, 64'd0, 64'h8765_4321_1234_5678, 0, 0, 64'd0, 0);
        issue("ld_d_8_keep",  1'b1, 1'b0, MD, 64'h8000_0008, 64'd0, 2'b00, 64'd0, 64'h1122_3344_5566_7788, 0, 0, 64'd0, 0);
        issue("st_d_last",    1'b1, 1'b1, MD, 64'h8000_7FF8, 64'h55AA_55AA_55AA_55AA, 2'b00, 64'd0, 64'd0, 0, 0, 64'd0, 0);
        issue("ld_d_last",    1'b1, 1'b0, MD, 64'h8000_7FF8, 64'd0, 2'b00, 64'd0, 64'h55AA_55AA_55AA_55AA, 0, 0, 64'd0, 0);
        issue("mmio_wr",      1'b1, 1'b1, MD, 64'h0200_4000, 64'd500, 2'b00, 64'd0, 64'd0, 1, 0, 64'd500, 0);
        issue("mmio_rd",      1'b1, 1'b0, MD, 64'h0200_4000, 64'd123, 2'b00, 64'd777, 64'd777, 0, 1, 64'd0, 0);
        issue("ld_d_8_mmio",  1'b1, 1'b0, MD, 64'h8000_0008, 64'd0, 2'b00, 64'd0, 64'h1122_3344_5566_7788, 0, 0, 64'd0, 0);
        issue("st_h_misal",   1'b1, 1'b1, MH, 64'h8000_0001, 64'h0000_0000_0000_FFFF, 2'b00, 64'd0, 64'd0, 0, 0, 64'd0, 0);
        issue("ld_d_0_misal", 1'b1, 1'b0, MD, 64'h8000_0000, 64'd0, 2'b00, 64'd0, 64'h8765_4321_1234_5678, 0, 0, 64'd0, 1);

        // Asynchronous clear of the sticky flag, checked between clock edges.
        @(posedge clk);
        #1;
        ena = 1'b0;
        wen = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (addr_err !== 1'b0) begin
            n_bad++;
            $display("FAIL async_err_clear: got err=%b, want err=0", addr_err);
        end else begin
            $display("ok   async_err_clear: err=%b", addr_err);
        end
        #1;
        rst_n = 1'b1;

        issue("ld_oor",       1'b1, 1'b0, MD, 64'h1000_0000, 64'd0, 2'b00, 64'd0, 64'd0, 0, 0, 64'd0, 0);
        issue("ld_d_8_oor",   1'b1, 1'b0, MD, 64'h8000_0008, 64'd0, 2'b00, 64'd0, 64'h1122_3344_5566_7788, 0, 0, 64'd0, 1);
        issue("rst_mid_wr",   1'b0, 1'b1, MD, 64'h8000_0008, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 64'd0, 64'd0, 0, 0, 64'd0, 0);
        issue("ld_d_8_rst",   1'b1, 1'b0, MD, 64'h8000_0008, 64'd0, 2'b00, 64'd0, 64'h1122_3344_5566_7788, 0, 0, 64'd0, 0);
        issue("ld_bad_mask",  1'b1, 1'b0, 4'b0011, 64'h8000_0008, 64'd0, 2'b00, 64'd0, 64'd0, 0, 0, 64'd0, 0);
        issue("ld_d_8_mask",  1'b1, 1'b0, MD, 64'h8000_0008, 64'd0, 2'b00, 64'd0, 64'h1122_3344_5566_7788, 0, 0, 64'd0, 1);
        idle();

        waited = 0;
        while (sb.size() != 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending entries, want 0", sb.size());
        end
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
